// File: rtl/mdr_op_sequencer.sv
// rtl/mdr_op_sequencer.sv - requester-side op sequencer for the MDR arithmetic engine
//
// Accepts one operation at a time on the op_* valid/ready port, registers the
// operands onto eng_*, pulses eng_start once, waits up to TIMEOUT cycles for
// the engine's one-cycle eng_ready, then holds the captured result on the
// res_* valid/ready port until it is consumed.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-low reset
//   op_valid/op_ready              upstream command handshake
//   op_code/op_x/op_y              00=MUL 01=DIV 10=SQRT 11=reserved, operands
//   eng_start/eng_op/eng_x/eng_y   start pulse and registered operands to engine
//   eng_ready/eng_result/eng_rem   engine done pulse and its outputs
//   res_valid/res_ready            downstream result handshake
//   res_data/res_rem/res_err       captured result, remainder, error flag
//   busy                           high whenever not idle
//
// Optional feature macro: MDR_DIVZERO_CHECK_EN
//   When defined, DIV with a zero divisor is answered locally (all-ones
//   quotient, remainder = dividend, error set) without starting the engine.

module mdr_op_sequencer #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [1:0]    op_code,
    input  logic [DW-1:0] op_x,
    input  logic [DW-1:0] op_y,
    output logic          eng_start,
    output logic [1:0]    eng_op,
    output logic [DW-1:0] eng_x,
    output logic [DW-1:0] eng_y,
    input  logic          eng_ready,
    input  logic [DW-1:0] eng_result,
    input  logic [DW-1:0] eng_rem,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic [DW-1:0] res_rem,
    output logic          res_err,
    output logic          busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    eng_op_q, eng_op_d;
    logic [DW-1:0] eng_x_q, eng_x_d;
    logic [DW-1:0] eng_y_q, eng_y_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic [DW-1:0] res_rem_q, res_rem_d;
    logic          res_err_q, res_err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          div_zero;

`ifdef MDR_DIVZERO_CHECK_EN
    assign div_zero = (eng_op_q == OP_DIV) && (eng_y_q == '0);
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            eng_op_q   <= '0;
            eng_x_q    <= '0;
            eng_y_q    <= '0;
            res_data_q <= '0;
            res_rem_q  <= '0;
            res_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            eng_op_q   <= eng_op_d;
            eng_x_q    <= eng_x_d;
            eng_y_q    <= eng_y_d;
            res_data_q <= res_data_d;
            res_rem_q  <= res_rem_d;
            res_err_q  <= res_err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        eng_op_d   = eng_op_q;
        eng_x_d    = eng_x_q;
        eng_y_d    = eng_y_q;
        res_data_d = res_data_q;
        res_rem_d  = res_rem_q;
        res_err_d  = res_err_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    eng_op_d = op_code;
                    eng_x_d  = op_x;
                    eng_y_d  = op_y;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                // Ops the engine cannot serve are answered here, skipping START.
                if (eng_op_q == OP_RSV) begin
                    res_data_d = '0;
                    res_rem_d  = '0;
                    res_err_d  = 1'b1;
                    state_d    = S_HOLD;
                end else if (div_zero) begin
                    res_data_d = '1;
                    res_rem_d  = eng_x_q;
                    res_err_d  = 1'b1;
                    state_d    = S_HOLD;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // eng_ready is checked first so a reply on the last cycle wins.
                if (eng_ready) begin
                    res_data_d = eng_result;
                    res_rem_d  = eng_rem;
                    res_err_d  = 1'b0;
                    state_d    = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    res_data_d = '0;
                    res_rem_d  = '0;
                    res_err_d  = 1'b1;
                    state_d    = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready  = (state_q == S_IDLE);
        eng_start = (state_q == S_START);
        res_valid = (state_q == S_HOLD);
        busy      = (state_q != S_IDLE);
    end

    assign eng_op   = eng_op_q;
    assign eng_x    = eng_x_q;
    assign eng_y    = eng_y_q;
    assign res_data = res_data_q;
    assign res_rem  = res_rem_q;
    assign res_err  = res_err_q;

endmodule

// File: doc/mdr_op_sequencer.md
Name: mdr_op_sequencer

Overview:
Requester-side controller for the multiply/divide/root (MDR) arithmetic engine. It accepts one operation at a time from an upstream valid/ready command port and presents operands to the engine. It pulses the engine's start input, waits for the engine's one-cycle done/ready pulse (with a timeout), and captures the result. The result is then held on a downstream valid/ready port until consumed. It sits between the system command source (register file or UART front-end) and the MDR engine plus its control unit.

Parameters:
DW, 16, operand/result width in bits
TIMEOUT, 64, max WAIT-state cycles before abort (must be >= 1)
CW, $clog2(TIMEOUT+1), timeout counter width (derived, localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
op_valid  in  1  upstream command valid
op_ready  out  1  upstream command ready
op_code  in  2  00=MUL, 01=DIV, 10=SQRT, 11=reserved
op_x  in  DW  operand X (dividend / radicand)
op_y  in  DW  operand Y (divisor; ignored for SQRT)
eng_start  out  1  one-cycle start pulse to engine
eng_op  out  2  registered op code to engine
eng_x  out  DW  registered operand X
eng_y  out  DW  registered operand Y
eng_ready  in  1  engine done pulse (one cycle)
eng_result  in  DW  engine quotient/product/root
eng_rem  in  DW  engine remainder (DIV/SQRT)
res_valid  out  1  downstream result valid
res_ready  in  1  downstream accept
res_data  out  DW  captured result
res_rem  out  DW  captured remainder
res_err  out  1  error flag (timeout, reserved op, optional div-by-zero)
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE. eng_start, res_valid, res_err, busy = 0. eng_op, eng_x, eng_y, res_data, res_rem, and timeout counter = 0. Reset mid-operation aborts with no result; any later eng_ready is ignored.
- States: IDLE, LOAD, START, WAIT, HOLD.
- IDLE: op_ready=1 (only state with op_ready=1). If op_valid=1, capture op_code/op_x/op_y into eng_op/eng_x/eng_y and go to LOAD. Accept cycle = T.
- LOAD (T+1): operands stable on eng_* outputs.
  - op_code=11 -> HOLD with res_data=0, res_rem=0, res_err=1. eng_start never pulses. res_valid at T+2.
  - Otherwise -> START.
- START (T+2): eng_start=1 for exactly this cycle. Counter cleared. -> WAIT.
- WAIT (from T+3): counter increments each cycle.
  - eng_ready=1 -> capture eng_result/eng_rem, res_err=0, -> HOLD. res_valid rises the next cycle.
  - No eng_ready and counter==TIMEOUT-1 -> res_data=0, res_rem=0, res_err=1, -> HOLD. This gives exactly TIMEOUT WAIT cycles.
  - eng_ready in the same cycle as timeout: eng_ready wins, no error.
- HOLD: res_valid=1. res_data/res_rem/res_err held stable. If res_ready=1 -> IDLE (res_valid low next cycle).
  - A new op cannot be accepted in the same cycle as the result handshake. Minimum op-to-op spacing is 1 IDLE cycle.
- eng_ready in IDLE/LOAD/START/HOLD: ignored, no state or data change.
- eng_x/eng_y/eng_op change only on op acceptance. They stay stable through WAIT and HOLD.
- busy = (state != IDLE), registered-state decode.

Optional Feature:
MDR_DIVZERO_CHECK_EN
- Defined: in LOAD, eng_op=01 with eng_y=0 -> HOLD directly. res_data = all ones ({DW{1'b1}}), res_rem = eng_x, res_err=1, no eng_start pulse. res_valid at T+2.
- Not defined: DIV by zero goes through START/WAIT like any op. Error only on timeout.

Test Plan:
- MUL x=3, y=5, engine model returns 15 after 17 cycles -> one eng_start pulse at T+2. res_valid one cycle after eng_ready, with res_data=0x000F, res_err=0. busy=1 from T+1 until the handshake.
- Engine never answers, TIMEOUT=64 -> exactly 64 WAIT cycles, then res_valid=1, res_data=0, res_err=1. A late eng_ready in HOLD/IDLE leaves the outputs unchanged.
- DIV x=100, y=7 (engine returns 14 r 2), with res_ready held low 10 cycles in HOLD -> res_data=14, res_rem=2 stable for all 10 cycles. op_ready=0 throughout. Returns to IDLE one cycle after res_ready=1.
- op_code=11, x=0x1234 -> eng_start never asserted, res_valid at T+2, res_err=1, res_data=0.
- DIV x=7, y=0 -> with MDR_DIVZERO_CHECK_EN: no eng_start, res_data=0xFFFF, res_rem=7, res_err=1 at T+2. Without it: eng_start pulses at T+2.
- SQRT x=81 started, rst pulsed low mid-WAIT, then engine asserts eng_ready -> all outputs at reset values, state IDLE, no res_valid. A new SQRT x=81 then completes with res_data=9.
